// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions for the read router: response codes, router
// state encoding and the lowest-set-bit select helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // DRAIN is only reachable when the read timeout is built in
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} rt_state_e;

  // One-hot of the lowest set bit; overlapping decode ranges resolve to the
  // lowest slave index
  function automatic logic [31:0] lsb_onehot(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/axil_err_slave_rd.sv
// One-beat DECERR read responder. Accepts a single AR one cycle after it is
// enabled, then holds a DECERR beat until the master takes it.
module axil_err_slave_rd
  import axil_pkg::*;
#(
  parameter int                DW    = 32,
  parameter logic [DW-1:0]     RDATA = '0
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          i_ar_en,
  input  logic          i_arvalid,
  output logic          o_arready,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic [1:0]    o_rresp,
  input  logic          i_rready
);

  logic r_arready;
  logic r_rvalid;
  logic w_ar_hs;

  assign w_ar_hs = i_ar_en & r_arready & i_arvalid;

  // arready rises one cycle after enable and drops after the handshake;
  // rvalid is set by the handshake and cleared when the beat is taken
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_arready <= i_ar_en & ~w_ar_hs & ~r_rvalid;
      if (w_ar_hs)                  r_rvalid <= 1'b1;
      else if (r_rvalid & i_rready) r_rvalid <= 1'b0;
    end
  end

  assign o_arready = r_arready & i_ar_en;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rvalid ? RDATA : '0;
  assign o_rresp   = r_rvalid ? RESP_DECERR : RESP_OKAY;

endmodule

// File: rtl/axil_router_rd.sv
// AXI-Lite read-channel router behind the address decoder. Latches the
// decoder select, forwards AR/R to one slave, answers unmapped reads with
// DECERR. Optional DATA-phase timeout with late-beat drain: AXIL_RD_TIMEOUT_EN.
module axil_router_rd
  import axil_pkg::*;
#(
  parameter int          NUMBER_SLAVE   = 4,
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  input  logic [NUMBER_SLAVE:0]                       slv_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]                   m_axil_araddr,
  input  logic                                        m_axil_arvalid,
  output logic                                        m_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]                   m_axil_rdata,
  output logic [1:0]                                  m_axil_rresp,
  output logic                                        m_axil_rvalid,
  input  logic                                        m_axil_rready,
  output logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  output logic [NUMBER_SLAVE-1:0]                     s_axil_arvalid,
  input  logic [NUMBER_SLAVE-1:0]                     s_axil_arready,
  input  logic [NUMBER_SLAVE-1:0][AXI_DATA_WIDTH-1:0] s_axil_rdata,
  input  logic [NUMBER_SLAVE-1:0][1:0]                s_axil_rresp,
  input  logic [NUMBER_SLAVE-1:0]                     s_axil_rvalid,
  output logic [NUMBER_SLAVE-1:0]                     s_axil_rready
);

  localparam int                      NS    = NUMBER_SLAVE;
  localparam int                      DW    = AXI_DATA_WIDTH;
  localparam logic [DW-1:0]           ERR_W = DW'(ERR_RDATA);

  rt_state_e           r_state, w_state_nx;
  logic [NS:0]         r_sel;
  logic [NS:0]         w_pick;
  logic                w_err_sel;
  logic                w_s_arready_sel, w_s_rvalid_sel;
  logic [DW-1:0]       w_s_rdata_sel;
  logic [1:0]          w_s_rresp_sel;
  logic                w_err_ar_en, w_err_arready, w_err_rvalid, w_err_rready;
  logic [DW-1:0]       w_err_rdata;
  logic [1:0]          w_err_rresp;

  assign s_axil_araddr   = {NS{m_axil_araddr}};
  assign w_pick          = (NS+1)'(lsb_onehot(32'(slv_valid)));
  assign w_err_sel       = r_sel[NS];
  assign w_s_arready_sel = |(r_sel[NS-1:0] & s_axil_arready);
  assign w_s_rvalid_sel  = |(r_sel[NS-1:0] & s_axil_rvalid);

  // R-channel mux of the selected slave (select is one-hot or zero)
  always_comb begin
    w_s_rdata_sel = '0;
    w_s_rresp_sel = '0;
    for (int i = 0; i < NS; i++) begin
      if (r_sel[i]) begin
        w_s_rdata_sel = w_s_rdata_sel | s_axil_rdata[i];
        w_s_rresp_sel = w_s_rresp_sel | s_axil_rresp[i];
      end
    end
  end

`ifdef AXIL_RD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] r_cnt;
  logic          w_to;

  assign w_to = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Counts slave-path DATA cycles without rvalid; saturates at the limit
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                              r_cnt <= '0;
    else if (r_state != DATA || w_err_sel)   r_cnt <= '0;
    else if (!w_s_rvalid_sel && !w_to)       r_cnt <= r_cnt + 1'b1;
  end
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES < 2);
`endif

  // State and select registers; select is cleared on every return to IDLE
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE && |slv_valid)             r_sel <= w_pick;
      else if (r_state != IDLE && w_state_nx == IDLE) r_sel <= '0;
    end
  end

  // Next state and all handshake/data routing
  always_comb begin
    w_state_nx     = r_state;
    m_axil_arready = 1'b0;
    m_axil_rvalid  = 1'b0;
    m_axil_rdata   = '0;
    m_axil_rresp   = RESP_OKAY;
    s_axil_arvalid = '0;
    s_axil_rready  = '0;
    w_err_ar_en    = 1'b0;
    w_err_rready   = 1'b0;
    case (r_state)
      IDLE: if (|slv_valid) w_state_nx = ADDR;
      ADDR: begin
        if (w_err_sel) begin
          w_err_ar_en    = 1'b1;
          m_axil_arready = w_err_arready;
        end else begin
          s_axil_arvalid = r_sel[NS-1:0] & {NS{m_axil_arvalid}};
          m_axil_arready = w_s_arready_sel;
        end
        if (m_axil_arvalid && m_axil_arready) w_state_nx = DATA;
      end
      DATA: begin
        if (w_err_sel) begin
          m_axil_rvalid = w_err_rvalid;
          m_axil_rdata  = w_err_rdata;
          m_axil_rresp  = w_err_rresp;
          w_err_rready  = m_axil_rready;
          if (w_err_rvalid && m_axil_rready) w_state_nx = IDLE;
`ifdef AXIL_RD_TIMEOUT_EN
        end else if (w_to) begin
          m_axil_rvalid = 1'b1;
          m_axil_rdata  = ERR_W;
          m_axil_rresp  = RESP_SLVERR;
          if (m_axil_rready) w_state_nx = DRAIN;
`endif
        end else begin
          m_axil_rvalid = w_s_rvalid_sel;
          m_axil_rdata  = w_s_rdata_sel;
          m_axil_rresp  = w_s_rresp_sel;
          s_axil_rready = r_sel[NS-1:0] & {NS{m_axil_rready}};
          if (w_s_rvalid_sel && m_axil_rready) w_state_nx = IDLE;
        end
      end
      DRAIN: begin
`ifdef AXIL_RD_TIMEOUT_EN
        // Swallow the late beat of the timed-out slave
        s_axil_rready = r_sel[NS-1:0];
        if (w_s_rvalid_sel) w_state_nx = IDLE;
`else
        w_state_nx = IDLE;
`endif
      end
      default: w_state_nx = IDLE;
    endcase
  end

  axil_err_slave_rd #(.DW(DW), .RDATA(ERR_W)) u_err (
    .aclk      (aclk),
    .areset    (areset),
    .i_ar_en   (w_err_ar_en),
    .i_arvalid (m_axil_arvalid),
    .o_arready (w_err_arready),
    .o_rvalid  (w_err_rvalid),
    .o_rdata   (w_err_rdata),
    .o_rresp   (w_err_rresp),
    .i_rready  (w_err_rready)
  );

endmodule
